// File: rtl/fifo_rd_checker.sv
// Read-side consumer for the 16->32 asymmetric FIFO demo: drains after prog-full
// and checks every returned word against the packed incrementing 16-bit sequence.
module fifo_rd_checker #(
  parameter logic [15:0] START_VALUE = 16'h0001,
  parameter int          CNT_WIDTH   = 16,
  parameter bit          RESYNC      = 1'b1
) (
  input  logic                 rd_clk,
  input  logic                 sys_rst,
  input  logic                 rst_busy_i,
  input  logic                 prog_full_i,
  input  logic                 empty_i,
  input  logic                 stop_rd_n_i,
  input  logic                 rd_valid_i,
  input  logic [31:0]          rdata_i,
  output logic                 rd_en_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic [31:0]          first_err_data_o,
  output logic [31:0]          first_err_exp_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, STREAM = 2'd2, HOLD = 2'd3} state_t;

  state_t      state;
  logic [15:0] exp_val;
  logic [31:0] exp_word;
  logic        mismatch;

  assign exp_word = {exp_val, exp_val + 16'd1};
  assign mismatch = (rdata_i != exp_word);
  assign state_o  = state;

  // Read control; prog-full only arms the first burst, afterwards HOLD resumes on ~empty.
  always_ff @(posedge rd_clk) begin
    if (sys_rst || rst_busy_i) begin
      state   <= IDLE;
      rd_en_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_en_o <= 1'b0;
          state   <= ARMED;
        end
        ARMED: begin
          rd_en_o <= 1'b0;
          if (prog_full_i) state <= STREAM;
        end
        STREAM: begin
          rd_en_o <= ~empty_i & stop_rd_n_i;
          if (empty_i || !stop_rd_n_i) state <= HOLD;
        end
        default: begin
          rd_en_o <= 1'b0;
          if (!empty_i && stop_rd_n_i) state <= STREAM;
        end
      endcase
    end
  end

  // Checker runs in every state so late returns after a pause or rst_busy are still seen.
  always_ff @(posedge rd_clk) begin
    if (sys_rst) begin
      exp_val          <= START_VALUE;
      error_o          <= 1'b0;
      err_cnt_o        <= '0;
      word_cnt_o       <= '0;
      first_err_data_o <= '0;
      first_err_exp_o  <= '0;
    end else if (rd_valid_i) begin
      word_cnt_o <= word_cnt_o + 1'b1;
      if (!mismatch) begin
        exp_val <= exp_val + 16'd2;
      end else begin
        error_o <= 1'b1;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
        if (!error_o) begin
          first_err_data_o <= rdata_i;
          first_err_exp_o  <= exp_word;
        end
        exp_val <= RESYNC ? (rdata_i[31:16] + 16'd2) : (exp_val + 16'd2);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench: a small FIFO model feeds the default instance; parameter
// variants (wrap, no-resync, 4-bit counters) are driven with direct vectors.
module tb_fifo_rd_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst, rst_busy, prog_full, stop_rd_n;
  logic        model_en, d_valid, load;
  logic [31:0] d_data, inj;
  int          load_n;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = 32'h0;
  logic [15:0] nv      = 16'h0001;
  int          cnt     = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic        stuck;

  wire        empty    = (cnt == 0);
  wire        rd_valid = model_en ? m_valid : d_valid;
  wire [31:0] rdata    = model_en ? m_data : d_data;

  logic        rd_en0, err0, rd_enw, errw, rd_enn, errn, rd_ens, errs;
  logic [15:0] ec0, wc0, ecw, wcw, ecn, wcn;
  logic [3:0]  ecs, wcs;
  logic [31:0] fd0, fe0, fdw, few, fdn, fen, fds, fes;
  logic [1:0]  st0, stw, stn, sts;

  fifo_rd_checker u0 (
    .rd_clk(clk), .sys_rst(sys_rst), .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .stop_rd_n_i(stop_rd_n), .rd_valid_i(rd_valid), .rdata_i(rdata),
    .rd_en_o(rd_en0), .error_o(err0), .err_cnt_o(ec0), .word_cnt_o(wc0),
    .first_err_data_o(fd0), .first_err_exp_o(fe0), .state_o(st0));

  fifo_rd_checker #(.START_VALUE(16'hFFFD)) u_wrap (
    .rd_clk(clk), .sys_rst(sys_rst), .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .stop_rd_n_i(stop_rd_n), .rd_valid_i(rd_valid), .rdata_i(rdata),
    .rd_en_o(rd_enw), .error_o(errw), .err_cnt_o(ecw), .word_cnt_o(wcw),
    .first_err_data_o(fdw), .first_err_exp_o(few), .state_o(stw));

  fifo_rd_checker #(.RESYNC(1'b0)) u_nr (
    .rd_clk(clk), .sys_rst(sys_rst), .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .stop_rd_n_i(stop_rd_n), .rd_valid_i(rd_valid), .rdata_i(rdata),
    .rd_en_o(rd_enn), .error_o(errn), .err_cnt_o(ecn), .word_cnt_o(wcn),
    .first_err_data_o(fdn), .first_err_exp_o(fen), .state_o(stn));

  fifo_rd_checker #(.CNT_WIDTH(4)) u_sat (
    .rd_clk(clk), .sys_rst(sys_rst), .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .stop_rd_n_i(stop_rd_n), .rd_valid_i(rd_valid), .rdata_i(rdata),
    .rd_en_o(rd_ens), .error_o(errs), .err_cnt_o(ecs), .word_cnt_o(wcs),
    .first_err_data_o(fds), .first_err_exp_o(fes), .state_o(sts));

  // FIFO model: registered read, one-cycle latency, reads on empty are ignored.
  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (rd_en0 && cnt > 0) begin
      m_valid <= 1'b1;
      m_data  <= {nv, nv + 16'd1} ^ inj;
      nv      <= nv + 16'd2;
    end
    cnt <= cnt + (load ? load_n : 0) - ((rd_en0 && cnt > 0) ? 1 : 0);
  end

  task automatic pulse_rst();
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic load_words(input int n);
    load_n = n; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drive(input logic [31:0] w);
    d_valid = 1'b1; d_data = w;
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rd_en0 !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en0); end
    checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st0); end
    checks++; if (err0 !== 1'b0 || ec0 !== 16'd0 || wc0 !== 16'd0) begin errors++;
      $display("FAIL reset_counters got err=%b ec=%h wc=%h exp 0/0/0", err0, ec0, wc0); end
    checks++; if (fd0 !== 32'h0 || fe0 !== 32'h0) begin errors++;
      $display("FAIL reset_first_err got %h/%h exp 0/0", fd0, fe0); end
    sys_rst = 1'b0;
  endtask

  task automatic test_stream();
    load_words(64);
    rst_busy = 1'b0;
    @(negedge clk);
    checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL armed_state got %0d exp 1", st0); end
    prog_full = 1'b1;
    @(negedge clk);
    checks++; if (st0 !== 2'd2 || rd_en0 !== 1'b0) begin errors++;
      $display("FAIL trigger_edge1 got st=%0d rd_en=%b exp 2/0", st0, rd_en0); end
    @(negedge clk);
    checks++; if (rd_en0 !== 1'b1) begin errors++; $display("FAIL trigger_edge2 got rd_en=%b exp 1", rd_en0); end
    for (int i = 0; i < 200 && st0 != 2'd3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (st0 !== 2'd3 || rd_en0 !== 1'b0) begin errors++;
      $display("FAIL drain_hold got st=%0d rd_en=%b exp 3/0", st0, rd_en0); end
    checks++; if (wc0 !== 16'd64) begin errors++; $display("FAIL drain_word_cnt got %0d exp 64", wc0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL drain_error got %b exp 0", err0); end
  endtask

  task automatic test_stop();
    load_words(20);
    for (int i = 0; i < 20 && rd_en0 != 1'b1; i++) @(negedge clk);
    checks++; if (rd_en0 !== 1'b1 || st0 !== 2'd2) begin errors++;
      $display("FAIL resume_from_hold got rd_en=%b st=%0d exp 1/2", rd_en0, st0); end
    repeat (3) @(negedge clk);
    stop_rd_n = 1'b0;
    @(negedge clk);
    checks++; if (rd_en0 !== 1'b0 || st0 !== 2'd3) begin errors++;
      $display("FAIL stop_hold got rd_en=%b st=%0d exp 0/3", rd_en0, st0); end
    stuck = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (rd_en0 !== 1'b0 || st0 !== 2'd3) stuck = 1'b1;
    end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL stop_paused got leak=%b exp 0", stuck); end
    stop_rd_n = 1'b1;
    for (int i = 0; i < 20 && st0 != 2'd2; i++) @(negedge clk);
    for (int i = 0; i < 100 && st0 != 2'd3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (wc0 !== 16'd84 || err0 !== 1'b0) begin errors++;
      $display("FAIL stop_continuity got wc=%0d err=%b exp 84/0", wc0, err0); end
  endtask

  task automatic test_mid_reset();
    load_words(30);
    for (int i = 0; i < 20 && rd_en0 != 1'b1; i++) @(negedge clk);
    @(negedge clk);
    inj = 32'hFFFF_0000;
    @(negedge clk);
    inj = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL inject_error got %b exp 1", err0); end
    pulse_rst();
    checks++; if (rd_en0 !== 1'b0 || st0 !== 2'd0) begin errors++;
      $display("FAIL midrst_fsm got rd_en=%b st=%0d exp 0/0", rd_en0, st0); end
    checks++; if (err0 !== 1'b0 || ec0 !== 16'd0 || wc0 !== 16'd0 || fd0 !== 32'h0 || fe0 !== 32'h0) begin errors++;
      $display("FAIL midrst_regs got err=%b ec=%h wc=%h fd=%h fe=%h exp all 0", err0, ec0, wc0, fd0, fe0); end
    rst_busy = 1'b1; prog_full = 1'b0;
    repeat (3) @(negedge clk);
    model_en = 1'b0;
  endtask

  task automatic test_resync();
    pulse_rst();
    drive(32'h0001_0002); drive(32'h0003_0004); drive(32'h0005_0006); drive(32'h0007_0008);
    drive(32'hDEAD_BEEF);
    drive(32'hDEAF_DEB0); drive(32'hDEB1_DEB2);
    checks++; if (err0 !== 1'b1 || ec0 !== 16'd1) begin errors++;
      $display("FAIL resync_count got err=%b ec=%0d exp 1/1", err0, ec0); end
    checks++; if (fd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL resync_first_data got %h exp deadbeef", fd0); end
    checks++; if (fe0 !== 32'h0009_000A) begin errors++; $display("FAIL resync_first_exp got %h exp 0009000a", fe0); end
    checks++; if (wc0 !== 16'd7) begin errors++; $display("FAIL resync_word_cnt got %0d exp 7", wc0); end
  endtask

  task automatic test_wrap();
    pulse_rst();
    drive(32'hFFFD_FFFE); drive(32'hFFFF_0000); drive(32'h0001_0002);
    checks++; if (errw !== 1'b0 || ecw !== 16'd0) begin errors++;
      $display("FAIL wrap_errors got err=%b ec=%0d exp 0/0", errw, ecw); end
    checks++; if (wcw !== 16'd3) begin errors++; $display("FAIL wrap_word_cnt got %0d exp 3", wcw); end
  endtask

  task automatic test_no_resync();
    pulse_rst();
    drive(32'h0001_0002); drive(32'h0100_0101); drive(32'h0102_0103); drive(32'h0104_0105);
    checks++; if (ecn !== 16'd3 || errn !== 1'b1) begin errors++;
      $display("FAIL noresync_count got err=%b ec=%0d exp 1/3", errn, ecn); end
    checks++; if (fdn !== 32'h0100_0101 || fen !== 32'h0003_0004) begin errors++;
      $display("FAIL noresync_first got %h/%h exp 01000101/00030004", fdn, fen); end
    checks++; if (ec0 !== 16'd1) begin errors++; $display("FAIL resync_contrast got %0d exp 1", ec0); end
  endtask

  task automatic test_saturate();
    pulse_rst();
    drive(32'h1234_5678);
    for (int i = 0; i < 15; i++) drive(32'h0);
    checks++; if (ecs !== 4'hF) begin errors++; $display("FAIL sat_reach got %h exp f", ecs); end
    for (int i = 0; i < 5; i++) drive(32'h0);
    checks++; if (ecs !== 4'hF || errs !== 1'b1) begin errors++;
      $display("FAIL sat_hold got ec=%h err=%b exp f/1", ecs, errs); end
    checks++; if (fds !== 32'h1234_5678 || fes !== 32'h0001_0002) begin errors++;
      $display("FAIL sat_first got %h/%h exp 12345678/00010002", fds, fes); end
    checks++; if (wcs !== 4'd5) begin errors++; $display("FAIL sat_word_wrap got %0d exp 5", wcs); end
  endtask

  initial begin
    sys_rst = 1'b1; rst_busy = 1'b1; prog_full = 1'b0; stop_rd_n = 1'b1;
    model_en = 1'b1; d_valid = 1'b0; d_data = 32'h0; inj = 32'h0;
    load = 1'b0; load_n = 0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stream();
    test_stop();
    test_mid_reset();
    test_resync();
    test_wrap();
    test_no_resync();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
